id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  Instruction decode / operand fetch stage directly upstream of the 8-bit ALU.
//  - Accepts 16-bit instructions, decodes the 4-bit opcode into alu_control.
//  - Reads the 8x8 register file and selects register or immediate operands.
//  - Registers {a, b, alu_control, rd, wb_en, mem flags} toward the ALU stage.
//  - Stalls RAW/WAW hazards with a per-register busy scoreboard.
// PARAMETERS
//  NREG   8   register count; register index width = 3
//  DW     8   data width; must match ALU operand width
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high
//  in_valid     in   1   instr is valid
//  in_ready     out  1   stage accepts instr this cycle
//  instr        in   16  [15:12] opcode, [11:9] rd, [8:6] rs, [7:0] imm
//  out_valid    out  1   ALU-side bundle valid
//  out_ready    in   1   ALU side consumes the bundle
//  a            out  DW  src1: reg[rd] (0 for MI/LD)
//  b            out  DW  src2: reg[rs], or imm for immediate-class ops
//  alu_control  out  4   = opcode, passed through unchanged
//  rd_out       out  3   destination register
//  wb_en_out    out  1   instruction writes rd (all ops except ST)
//  is_load      out  1   opcode 0000
//  is_store     out  1   opcode 0001; a carries store data reg[rd]
//  wb_valid     in   1   writeback strobe from last stage
//  wb_addr      in   3   writeback register
//  wb_data      in   DW  writeback data
// BEHAVIOUR
//  - Reset: every output reg, all NREG registers and all busy bits = 0.
//    in_ready then reads 1.
//  - Immediate class: 0000 0001 0010 1001 1011 1100 1101 1110 1111.
//    For these, b = imm. All other opcodes use b = reg[rs].
//  - Hazard (stall) condition:
//    - busy[rd] for any op;
//    - busy[rs] for register-class ops;
//    - busy[rd] for ops that read rd.
//  - in_ready = (!out_valid | out_ready) & !hazard.
//    in_ready is combinational; it does not depend on in_valid.
//  - Accept = in_valid & in_ready. On the next edge:
//    - output bundle loads;
//    - out_valid <= 1;
//    - busy[rd] <= 1 if wb_en.
//  - Otherwise, if out_ready, out_valid <= 0.
//  - Latency: 1 cycle, instruction accepted to out_valid.
//  - Throughput: 1/cycle with no hazards.
//  - Bundle holds stable while out_valid & !out_ready.
//  - wb_valid: reg[wb_addr] <= wb_data; busy[wb_addr] <= 0.
//  - Same-cycle wb clear and accept set on one register: the set wins.
//  - r0 is an ordinary register (not hard-wired zero).
//  - Reset mid-stall: bundle and scoreboard are discarded; no replay.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    - wb_valid masks busy[wb_addr] in the hazard check that same cycle.
//    - Operands read wb_data when the read index equals wb_addr.
//    - A dependent instr issues in the writeback cycle.
//  WB_BYPASS_EN undefined:
//    - No forwarding.
//    - A dependent instr issues the cycle after writeback (one extra stall).
// STRUCTURE
//  - Shared package id_pkg:
//    - opcode localparams (OP_LD .. OP_XRI, 4'b0000..4'b1011 per ALU encoding);
//    - is_imm(opcode) function;
//    - instr field slice constants.
//  - One sub-module, id_regfile:
//    - NREG x DW storage;
//    - 2 async read ports, 1 sync write port;
//    - WB_BYPASS_EN forwarding mux.
//  - The scoreboard and handshake stay in id_stage.
// TESTING
//  1 Reset: assert reset mid-transaction.
//    -> out_valid=0, a=b=0, in_ready=1, all busy bits 0.
//  2 wb r1=8'h05; issue SUM rd=2 rs=1 (16'h4440), out_ready=1.
//    -> next cycle out_valid=1, alu_control=4'b0100, b=8'h05, rd_out=2, wb_en_out=1.
//  3 SMI rd=3 imm=8'hFF (16'hC6FF).
//    -> b=8'hFF, alu_control=4'b1100.
//    Then SB rd=4 rs=3: in_ready=0 until wb_addr=3.
//  4 Stall: out_ready=0 for 3 cycles with in_valid=1.
//    -> bundle constant, in_ready=0.
//    Release -> next instr accepted the same cycle.
//  5 Bypass: dependent instr present when wb_valid, wb_addr=3, wb_data=8'h2A.
//    -> with WB_BYPASS_EN: accepted that cycle, b=8'h2A.
//    -> without WB_BYPASS_EN: accepted one cycle later.
//  6 ST rd=5 imm=8'h10.
//    -> is_store=1, wb_en_out=0, a=reg[5], busy[5] unchanged.

Source files
------------

// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg : shared definitions for the instruction decode / operand fetch stage
//
//  - opcode constants (ALU encoding, OP_LD .. OP_XRI plus the upper
//    immediate-class opcodes)
//  - instruction field slice positions
//  - is_imm()   : opcode selects the immediate as operand b
//  - reads_rd() : opcode uses reg[rd] as operand a
// ---------------------------------------------------------------------------
package id_pkg;

  localparam int DEF_NREG = 8;
  localparam int DEF_DW   = 8;

  // Opcodes (ALU encoding)
  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_MI  = 4'b0010;
  localparam logic [3:0] OP_MR  = 4'b0011;
  localparam logic [3:0] OP_SUM = 4'b0100;
  localparam logic [3:0] OP_SB  = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_XR  = 4'b1000;
  localparam logic [3:0] OP_ADI = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_XRI = 4'b1011;
  localparam logic [3:0] OP_SMI = 4'b1100;
  localparam logic [3:0] OP_SBI = 4'b1101;
  localparam logic [3:0] OP_ANI = 4'b1110;
  localparam logic [3:0] OP_ORI = 4'b1111;

  // Instruction field positions: [15:12] opcode, [11:9] rd, [8:6] rs, [7:0] imm.
  // rs and imm overlap; which one is meaningful depends on the opcode class.
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS_HI  = 8;
  localparam int RS_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  function automatic logic is_imm(input logic [3:0] op);
    case (op)
      OP_LD, OP_ST, OP_MI, OP_ADI, OP_XRI,
      OP_SMI, OP_SBI, OP_ANI, OP_ORI: is_imm = 1'b1;
      default:                         is_imm = 1'b0;
    endcase
  endfunction

  // LD and MI take nothing from rd; every other op (ST included, as store
  // data) reads reg[rd] into operand a.
  function automatic logic reads_rd(input logic [3:0] op);
    reads_rd = (op != OP_LD) && (op != OP_MI);
  endfunction

endpackage

// File: rtl/id_regfile.sv
// ---------------------------------------------------------------------------
// id_regfile : NREG x DW register file for the decode stage
//
//  clk, rst       clock, asynchronous active-high reset (clears all registers)
//  ra1 / rd1      async read port 1 (rd field)
//  ra2 / rd2      async read port 2 (rs field)
//  we, wa, wd     synchronous write port (writeback)
//
// Build option WB_BYPASS_EN: a read whose index matches the write address in
// the same cycle returns the write data instead of the stored value.
// r0 is an ordinary register.
// ---------------------------------------------------------------------------
module id_regfile
  import id_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int DW   = DEF_DW,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

`ifdef WB_BYPASS_EN
  assign rd1 = (we && (wa == ra1)) ? wd : mem[ra1];
  assign rd2 = (we && (wa == ra2)) ? wd : mem[ra2];
`else
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
`endif

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : instruction decode / operand fetch stage feeding the 8-bit ALU
//
//  clk, reset            clock, asynchronous active-high reset
//  in_valid/in_ready     instruction handshake (instr: [15:12] op, [11:9] rd,
//                        [8:6] rs, [7:0] imm)
//  out_valid/out_ready   ALU-side handshake for the registered bundle
//  a, b, alu_control,    registered bundle: operands, opcode pass-through,
//  rd_out, wb_en_out,    destination, write-enable and memory flags
//  is_load, is_store
//  wb_valid/addr/data    writeback from the last stage: updates the register
//                        file and clears the register's busy bit
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready is combinational from out_valid, out_ready and the hazard
// check and never looks at in_valid. Once out_valid is high the bundle holds
// stable until out_ready is seen.
//
// Build option WB_BYPASS_EN: a writeback masks its register's busy bit in the
// same cycle and its data is forwarded to the operand reads, so a dependent
// instruction issues in the writeback cycle instead of the cycle after.
// ---------------------------------------------------------------------------
module id_stage
  import id_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int DW   = DEF_DW,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [3:0]    alu_control,
  output logic [AW-1:0] rd_out,
  output logic          wb_en_out,
  output logic          is_load,
  output logic          is_store,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  logic [3:0]    op;
  logic [AW-1:0] rd_f;
  logic [AW-1:0] rs_f;
  logic [7:0]    imm_f;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] rs_val;
  logic          op_imm;
  logic          op_wb;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_eff;
  logic          hazard;
  logic          accept;

  assign op     = instr[OPC_HI:OPC_LO];
  assign rd_f   = instr[RD_HI:RD_LO];
  assign rs_f   = instr[RS_HI:RS_LO];
  assign imm_f  = instr[IMM_HI:IMM_LO];
  assign op_imm = is_imm(op);
  assign op_wb  = (op != OP_ST);

  id_regfile #(.NREG(NREG), .DW(DW), .AW(AW)) u_regfile (
    .clk (clk),
    .rst (reset),
    .ra1 (rd_f),
    .rd1 (rd_val),
    .ra2 (rs_f),
    .rd2 (rs_val),
    .we  (wb_valid),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  // Busy view used by the hazard check.
  always_comb begin
    busy_eff = busy;
`ifdef WB_BYPASS_EN
    if (wb_valid) busy_eff[wb_addr] = 1'b0;
`endif
  end

  // busy[rd] stalls every op: it covers both WAW and the ops that read rd.
  assign hazard   = busy_eff[rd_f] | (!op_imm & busy_eff[rs_f]);
  assign in_ready = (!out_valid | out_ready) & !hazard;
  assign accept   = in_valid & in_ready;

  // Scoreboard: the accept set comes after the writeback clear so that it
  // wins when both hit the same register in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wb_valid)         busy[wb_addr] <= 1'b0;
      if (accept && op_wb)  busy[rd_f]    <= 1'b1;
    end
  end

  // Output bundle toward the ALU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      a           <= '0;
      b           <= '0;
      alu_control <= '0;
      rd_out      <= '0;
      wb_en_out   <= 1'b0;
      is_load     <= 1'b0;
      is_store    <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      a           <= reads_rd(op) ? rd_val : '0;
      b           <= op_imm ? DW'(imm_f) : rs_val;
      alu_control <= op;
      rd_out      <= rd_f;
      wb_en_out   <= op_wb;
      is_load     <= (op == OP_LD);
      is_store    <= (op == OP_ST);
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
